// File: rtl/master_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : master_tx_engine
// Function : Serial master transmit engine. Latches a request, arbitrates,
//            shifts select/address/data LANES bits per beat, reports done/error.
//            Optional watchdog enabled by defining MASTER_TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module master_tx_engine #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int LANES     = 1,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SLAVE_LEN-1:0] slave_select,
  input  logic [1:0]           instruction,
  input  logic [ADDR_LEN-1:0]  address,
  input  logic [DATA_LEN-1:0]  data,
  input  logic                 rx_done,
  input  logic                 slave_ready,
  input  logic                 arbitor_busy,
  input  logic                 bus_busy,
  input  logic                 approval_grant,
  output logic                 master_ready,
  output logic                 approval_request,
  output logic [LANES-1:0]     tx_slave_select,
  output logic                 master_valid,
  output logic                 write_en,
  output logic                 read_en,
  output logic [LANES-1:0]     tx_address,
  output logic [LANES-1:0]     tx_data,
  output logic                 tx_done,
  output logic                 tx_error
);
  localparam int c_SB   = (SLAVE_LEN + LANES - 1) / LANES;
  localparam int c_AB   = (ADDR_LEN + LANES - 1) / LANES;
  localparam int c_DB   = (DATA_LEN + LANES - 1) / LANES;
  localparam int c_NB   = (c_AB > c_DB) ? c_AB : c_DB;
  localparam int c_MAXB = (c_NB > c_SB) ? c_NB : c_SB;
  localparam int c_BW   = $clog2(c_MAXB + 1);
  localparam int c_RW   = $clog2(MAX_RETRY + 2);
  localparam int c_PW   = c_MAXB * LANES;

  localparam logic [c_BW-1:0] c_SB_LAST   = c_BW'(c_SB - 1);
  localparam logic [c_BW-1:0] c_NB_LAST   = c_BW'(c_NB - 1);
  localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(MAX_RETRY);

  localparam logic [3:0] c_S_IDLE       = 4'd0;
  localparam logic [3:0] c_S_ARB        = 4'd1;
  localparam logic [3:0] c_S_SEL        = 4'd2;
  localparam logic [3:0] c_S_WAIT_BUS   = 4'd3;
  localparam logic [3:0] c_S_WAIT_GRANT = 4'd4;
  localparam logic [3:0] c_S_HANDSHAKE  = 4'd5;
  localparam logic [3:0] c_S_XFER       = 4'd6;
  localparam logic [3:0] c_S_READ_WAIT  = 4'd7;
  localparam logic [3:0] c_S_DONE       = 4'd8;
  localparam logic [3:0] c_S_ERROR      = 4'd9;

  generate
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
      $error("master_tx_engine: LANES must be in 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("master_tx_engine: TIMEOUT must be in 1..65535");
    end
  endgenerate

  logic [3:0]      r_state, w_next;
  logic [c_BW-1:0] r_beat;
  logic [c_RW-1:0] r_retry;
  logic [c_PW-1:0] r_sel, r_addr, r_data;
  logic            r_rd;
  logic            w_timeout;
  logic            w_xfer;

`ifdef MASTER_TX_TIMEOUT_EN
  localparam logic [15:0] c_WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_wdog;
  logic        w_wd_state;

  assign w_wd_state = (r_state == c_S_WAIT_BUS)  || (r_state == c_S_WAIT_GRANT) ||
                      (r_state == c_S_HANDSHAKE) || (r_state == c_S_READ_WAIT);

  // Cycle count of the current wait state; restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset || (w_next != r_state)) r_wdog <= '0;
    else if (w_wd_state)              r_wdog <= r_wdog + 16'd1;
  end

  assign w_timeout = w_wd_state && (r_wdog == c_WD_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
      r_beat  <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == c_S_HANDSHAKE && w_next == c_S_XFER) r_beat <= c_BW'(1);
      else if (w_next != r_state)                         r_beat <= '0;
      else if (r_state == c_S_SEL || r_state == c_S_XFER) r_beat <= r_beat + c_BW'(1);
      if (r_state == c_S_IDLE && instruction[1])                  r_retry <= '0;
      else if (r_state == c_S_WAIT_GRANT && w_next == c_S_ARB)    r_retry <= r_retry + c_RW'(1);
    end
  end

  // Fields are zero-padded so exhausted beats read back as 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_rd   <= 1'b0;
    end else if (r_state == c_S_IDLE && instruction[1]) begin
      r_sel  <= c_PW'(slave_select);
      r_addr <= c_PW'(address);
      r_data <= c_PW'(data);
      r_rd   <= instruction[0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE:       if (instruction[1]) w_next = c_S_ARB;
      c_S_ARB:        if (!arbitor_busy)  w_next = c_S_SEL;
      c_S_SEL:        if (r_beat == c_SB_LAST) w_next = bus_busy ? c_S_WAIT_BUS : c_S_WAIT_GRANT;
      c_S_WAIT_BUS: begin
        if (!bus_busy)      w_next = c_S_WAIT_GRANT;
        else if (w_timeout) w_next = c_S_ERROR;
      end
      c_S_WAIT_GRANT: begin
        if (approval_grant) w_next = c_S_HANDSHAKE;
        else if (bus_busy)  w_next = (r_retry == c_RETRY_MAX) ? c_S_ERROR : c_S_ARB;
        else if (w_timeout) w_next = c_S_ERROR;
      end
      c_S_HANDSHAKE: begin
        if (slave_ready) begin
          if (c_NB == 1) w_next = r_rd ? c_S_READ_WAIT : c_S_DONE;
          else           w_next = c_S_XFER;
        end else if (w_timeout) begin
          w_next = c_S_ERROR;
        end
      end
      c_S_XFER:       if (r_beat == c_NB_LAST) w_next = r_rd ? c_S_READ_WAIT : c_S_DONE;
      c_S_READ_WAIT: begin
        if (rx_done)        w_next = c_S_IDLE;
        else if (w_timeout) w_next = c_S_ERROR;
      end
      c_S_DONE:       w_next = c_S_IDLE;
      c_S_ERROR:      w_next = c_S_IDLE;
      default:        w_next = c_S_IDLE;
    endcase
  end

  assign w_xfer = (r_state == c_S_HANDSHAKE) || (r_state == c_S_XFER);

  always_comb begin
    master_ready     = (r_state == c_S_IDLE);
    approval_request = (r_state == c_S_ARB) || (r_state == c_S_SEL);
    master_valid     = w_xfer;
    write_en         = w_xfer && !r_rd;
    read_en          = w_xfer && r_rd;
    tx_slave_select  = '0;
    tx_address       = '0;
    tx_data          = '0;
    if (r_state == c_S_SEL) tx_slave_select = r_sel[LANES*int'(r_beat) +: LANES];
    if (w_xfer) begin
      tx_address = r_addr[LANES*int'(r_beat) +: LANES];
      tx_data    = r_data[LANES*int'(r_beat) +: LANES];
    end
    tx_done  = ((r_state == c_S_XFER) && (r_beat == c_NB_LAST)) ||
               ((c_NB == 1) && (r_state == c_S_HANDSHAKE) && slave_ready);
    tx_error = (r_state == c_S_ERROR);
  end

endmodule
`default_nettype wire

// File: tb/tb_master_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_tx_engine
// Function : Directed self-checking bench: LANES=2 writes, LANES=1 read,
//            retry exhaustion, mid-transfer reset and watchdog behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_master_tx_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  slave_select;
  logic [11:0] address;
  logic [7:0]  data;
  logic        rx_done, slave_ready, arbitor_busy, bus_busy, approval_grant;
  logic [1:0]  instr_a, instr_b;

  logic       a_mr, a_areq, a_val, a_wen, a_ren, a_done, a_err;
  logic [1:0] a_sel, a_addr, a_data;
  logic       b_mr, b_areq, b_val, b_wen, b_ren, b_done, b_err;
  logic [0:0] b_sel, b_addr, b_data;

  logic [31:0] a_vec, b_vec;
  assign a_vec = {19'd0, a_mr, a_areq, a_val, a_wen, a_ren, a_done, a_err, a_sel, a_addr, a_data};
  assign b_vec = {22'd0, b_mr, b_areq, b_val, b_wen, b_ren, b_done, b_err, b_sel, b_addr, b_data};

  int n_checks = 0;
  int n_errors = 0;

  master_tx_engine #(.SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .LANES(2),
                     .MAX_RETRY(3), .TIMEOUT(20)) u_dut_a (
    .clk(clk), .reset(reset), .slave_select(slave_select), .instruction(instr_a),
    .address(address), .data(data), .rx_done(rx_done), .slave_ready(slave_ready),
    .arbitor_busy(arbitor_busy), .bus_busy(bus_busy), .approval_grant(approval_grant),
    .master_ready(a_mr), .approval_request(a_areq), .tx_slave_select(a_sel),
    .master_valid(a_val), .write_en(a_wen), .read_en(a_ren), .tx_address(a_addr),
    .tx_data(a_data), .tx_done(a_done), .tx_error(a_err)
  );

  master_tx_engine #(.SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .LANES(1),
                     .MAX_RETRY(3), .TIMEOUT(20)) u_dut_b (
    .clk(clk), .reset(reset), .slave_select(slave_select), .instruction(instr_b),
    .address(address), .data(data), .rx_done(rx_done), .slave_ready(slave_ready),
    .arbitor_busy(arbitor_busy), .bus_busy(bus_busy), .approval_grant(approval_grant),
    .master_ready(b_mr), .approval_request(b_areq), .tx_slave_select(b_sel),
    .master_valid(b_val), .write_en(b_wen), .read_en(b_ren), .tx_address(b_addr),
    .tx_data(b_data), .tx_done(b_done), .tx_error(b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] va(input logic mr, areq, val, wen, ren, done, err,
                                     input logic [1:0] s, a, d);
    return 32'({mr, areq, val, wen, ren, done, err, s, a, d});
  endfunction

  function automatic logic [31:0] vb(input logic mr, areq, val, wen, ren, done, err, s, a, d);
    return 32'({mr, areq, val, wen, ren, done, err, s, a, d});
  endfunction

  // Full write on the LANES=2 engine; abort_beat >= 1 asserts reset on that XFER beat.
  task automatic run_write_a(input logic [1:0] s, input logic [11:0] a, input logic [7:0] d,
                             input int busy_n, input int grant_n, input int ready_n,
                             input int abort_beat);
    logic [1:0] ea, ed;
    @(negedge clk);
    slave_select = s; address = a; data = d; instr_a = 2'b10;
    arbitor_busy = 1'b1; bus_busy = 1'b0; approval_grant = 1'b0; slave_ready = 1'b0;
    #1 check_eq("w_idle", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    @(negedge clk); instr_a = 2'b00;
    #1 check_eq("w_arb_busy", a_vec, va(0,1,0,0,0,0,0,2'b00,2'b00,2'b00));
    @(negedge clk); arbitor_busy = 1'b0;
    #1 check_eq("w_arb", a_vec, va(0,1,0,0,0,0,0,2'b00,2'b00,2'b00));
    @(negedge clk); bus_busy = (busy_n > 0);
    #1 check_eq("w_sel", a_vec, va(0,1,0,0,0,0,0,s,2'b00,2'b00));
    for (int i = 0; i < busy_n; i++) begin
      @(negedge clk); bus_busy = (i < busy_n - 1);
      #1 check_eq("w_wait_bus", a_vec, va(0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    end
    // Final grant cycle also raises bus_busy: grant must win.
    for (int i = 0; i <= grant_n; i++) begin
      @(negedge clk); approval_grant = (i == grant_n); bus_busy = (i == grant_n);
      #1 check_eq("w_wait_grant", a_vec, va(0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    end
    for (int i = 0; i <= ready_n; i++) begin
      @(negedge clk); approval_grant = 1'b0; bus_busy = 1'b0; slave_ready = (i == ready_n);
      #1 check_eq("w_handshake", a_vec, va(0,0,1,1,0,0,0,2'b00,a[1:0],d[1:0]));
    end
    for (int k = 1; k < 6; k++) begin
      @(negedge clk); slave_ready = 1'b0;
      if (k == 2) begin address = ~a; data = ~d; end
      if (k == abort_beat) reset = 1'b1;
      ea = 2'(a >> (2*k));
      ed = 2'(d >> (2*k));
      #1 check_eq("w_beat", a_vec, va(0,0,1,1,0,(k == 5),0,2'b00,ea,ed));
      if (k == abort_beat) begin
        @(negedge clk); reset = 1'b0;
        #1 check_eq("w_abort_reset", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
        return;
      end
    end
    @(negedge clk);
    #1 check_eq("w_done_state", a_vec, va(0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    @(negedge clk);
    #1 check_eq("w_ready_again", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
  endtask

  initial begin
    logic [1:0]  sv;
    logic [11:0] av;
    logic [7:0]  dv;
    reset = 1'b1; instr_a = 2'b00; instr_b = 2'b00; slave_select = '0; address = '0;
    data = '0; rx_done = 1'b0; slave_ready = 1'b0; arbitor_busy = 1'b0;
    bus_busy = 1'b0; approval_grant = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1 check_eq("reset_a", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    check_eq("reset_b", b_vec, vb(1,0,0,0,0,0,0,0,0,0));

    run_write_a(2'b10, 12'hA5C, 8'h3C, 0, 0, 0, -1);

    // Read on the LANES=1 engine: two select beats, twelve address beats.
    sv = 2'b10; av = 12'hA5C; dv = 8'h3C;
    @(negedge clk);
    slave_select = sv; address = av; data = dv; instr_b = 2'b11;
    arbitor_busy = 1'b0; bus_busy = 1'b0; approval_grant = 1'b1; slave_ready = 1'b1;
    #1 check_eq("r_idle", b_vec, vb(1,0,0,0,0,0,0,0,0,0));
    @(negedge clk); instr_b = 2'b00;
    #1 check_eq("r_arb", b_vec, vb(0,1,0,0,0,0,0,0,0,0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check_eq("r_sel", b_vec, vb(0,1,0,0,0,0,0,sv[k],0,0));
    end
    @(negedge clk);
    #1 check_eq("r_wait_grant", b_vec, vb(0,0,0,0,0,0,0,0,0,0));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1 check_eq("r_beat", b_vec, vb(0,0,1,0,1,(k == 11),0,0,1'(av >> k),1'(dv >> k)));
    end
    approval_grant = 1'b0; slave_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check_eq("r_read_wait", b_vec, vb(0,0,0,0,0,0,0,0,0,0));
    end
    @(negedge clk); rx_done = 1'b1;
    #1 check_eq("r_rx_done", b_vec, vb(0,0,0,0,0,0,0,0,0,0));
    @(negedge clk); rx_done = 1'b0;
    #1 check_eq("r_idle_again", b_vec, vb(1,0,0,0,0,0,0,0,0,0));

    // Bus lost in WAIT_GRANT four times: three retries, then error.
    @(negedge clk);
    slave_select = 2'b01; address = 12'h123; data = 8'h45; instr_a = 2'b10;
    arbitor_busy = 1'b0; bus_busy = 1'b0; approval_grant = 1'b0; slave_ready = 1'b0;
    #1 check_eq("la_idle", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); instr_a = 2'b00; bus_busy = 1'b0;
      #1 check_eq("la_arb", a_vec, va(0,1,0,0,0,0,0,2'b00,2'b00,2'b00));
      @(negedge clk);
      #1 check_eq("la_sel", a_vec, va(0,1,0,0,0,0,0,2'b01,2'b00,2'b00));
      @(negedge clk); bus_busy = 1'b1;
      #1 check_eq("la_wait_grant", a_vec, va(0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    end
    @(negedge clk); bus_busy = 1'b0;
    #1 check_eq("la_error", a_vec, va(0,0,0,0,0,0,1,2'b00,2'b00,2'b00));
    @(negedge clk);
    #1 check_eq("la_idle_again", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));

    run_write_a(2'b11, 12'h5A3, 8'hC9, 0, 0, 0, 3);
    run_write_a(2'b01, 12'h3C7, 8'h96, 2, 2, 3, -1);

    // Slave never ready: watchdog fires if built in, otherwise the engine waits.
    @(negedge clk);
    slave_select = 2'b10; address = 12'h0F1; data = 8'h5E; instr_a = 2'b10;
    arbitor_busy = 1'b0; bus_busy = 1'b0; approval_grant = 1'b1; slave_ready = 1'b0;
    #1 check_eq("to_idle", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    @(negedge clk); instr_a = 2'b00;
    #1 check_eq("to_arb", a_vec, va(0,1,0,0,0,0,0,2'b00,2'b00,2'b00));
    @(negedge clk);
    #1 check_eq("to_sel", a_vec, va(0,1,0,0,0,0,0,2'b10,2'b00,2'b00));
    @(negedge clk);
    #1 check_eq("to_wait_grant", a_vec, va(0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); approval_grant = 1'b0;
      #1 check_eq("to_handshake", a_vec, va(0,0,1,1,0,0,0,2'b00,2'b01,2'b10));
    end
`ifdef MASTER_TX_TIMEOUT_EN
    @(negedge clk);
    #1 check_eq("to_error", a_vec, va(0,0,0,0,0,0,1,2'b00,2'b00,2'b00));
    @(negedge clk);
    #1 check_eq("to_ready", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
`else
    @(negedge clk); reset = 1'b1;
    #1 check_eq("to_still_waiting", a_vec, va(0,0,1,1,0,0,0,2'b00,2'b01,2'b10));
    @(negedge clk); reset = 1'b0;
    #1 check_eq("to_reset", a_vec, va(1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
